// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests an instruction at pc_in, waits for the
// memory response, issues it downstream and steers the external PC block.
//
// state | meaning
// IDLE  | inactive after reset, waits for start
// REQ   | memory request at pc_in, waits for grant
// WAIT  | granted, waits for rvalid (bounded by TIMEOUT)
// ISSUE | instruction presented downstream, PC update on accept
// HALT  | stopped by halt instruction or timeout, waits for start/redirect
module fetch_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pc_in,
    output logic        pc_enable,
    output logic        pc_load,
    output logic [7:0]  pc_load_value,
    output logic [2:0]  pc_step_size,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr_data,
    output logic [7:0]  instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [7:0]  redirect_target,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        drop_q, drop_d;
    logic [7:0]  tgt_q, tgt_d;
    logic [15:0] instr_data_q, instr_data_d;
    logic [7:0]  instr_pc_q, instr_pc_d;
    logic        err_q, err_d;

    logic [1:0]  op;
    logic [2:0]  step_field;
    logic        drop_now;
    logic [7:0]  drop_tgt;

    assign op         = instr_data_q[15:14];
    assign step_field = instr_data_q[13:11];
    // A redirect arriving in the same cycle as rvalid still discards the response.
    assign drop_now   = drop_q | redirect;
    assign drop_tgt   = redirect ? redirect_target : tgt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            drop_q       <= 1'b0;
            tgt_q        <= 8'd0;
            instr_data_q <= 16'd0;
            instr_pc_q   <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            drop_q       <= drop_d;
            tgt_q        <= tgt_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        drop_d       = drop_q;
        tgt_d        = tgt_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd0;
                    if (redirect) begin
                        drop_d = 1'b1;
                        tgt_d  = redirect_target;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (redirect) begin
                    drop_d = 1'b1;
                    tgt_d  = redirect_target;
                end
                if (imem_rvalid) begin
                    if (drop_now) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_data_d = imem_rdata;
                        instr_pc_d   = pc_in;
                        state_d      = S_ISSUE;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    drop_d  = 1'b0;
                    state_d = S_HALT;
                end
            end
            S_ISSUE: begin
                if (redirect) state_d = S_REQ;
                else if (instr_ready) state_d = (op == 2'b11) ? S_HALT : S_REQ;
            end
            S_HALT: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (start) begin
                    state_d = S_REQ;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_enable     = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 8'd0;
        pc_step_size  = 3'd0;
        imem_req      = 1'b0;
        imem_addr     = 8'd0;
        instr_valid   = 1'b0;
        case (state_q)
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_in;
                if (redirect && !imem_gnt) begin
                    pc_enable     = 1'b1;
                    pc_load       = 1'b1;
                    pc_load_value = redirect_target;
                end
            end
            S_WAIT: begin
                if (imem_rvalid && drop_now) begin
                    pc_enable     = 1'b1;
                    pc_load       = 1'b1;
                    pc_load_value = drop_tgt;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (redirect) begin
                    pc_enable     = 1'b1;
                    pc_load       = 1'b1;
                    pc_load_value = redirect_target;
                end else if (instr_ready && op != 2'b11) begin
                    pc_enable = 1'b1;
                    if (op == 2'b10) begin
                        pc_load       = 1'b1;
                        pc_load_value = instr_data_q[7:0];
                    end else if (op == 2'b01) begin
                        pc_step_size = 3'd2;
                    end else begin
                        pc_step_size = (step_field == 3'd0) ? 3'd1 : step_field;
                    end
                end
            end
            S_HALT: begin
                if (redirect) begin
                    pc_enable     = 1'b1;
                    pc_load       = 1'b1;
                    pc_load_value = redirect_target;
                end
            end
            default: ;
        endcase
    end

    assign busy       = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_ISSUE);
    assign err        = err_q;
    assign instr_data = instr_data_q;
    assign instr_pc   = instr_pc_q;

endmodule
